// File: rtl/val_drop_stream_pkg.sv
// Token encoding shared by the sparse-stream stages: control flag, stop/done helpers, FSM states.
package sam_tkn_pkg;

  localparam int          TKN_W        = 17;
  localparam int          CTRL_BIT     = 16;
  localparam logic [15:0] DONE_PAYLOAD = 16'h0100;
  localparam logic [7:0]  STOP_MAX     = 8'hFF;

  typedef enum logic {STREAM, DRAIN} vds_state_t;

  function automatic logic is_ctrl(input logic [TKN_W-1:0] tkn);
    return tkn[CTRL_BIT];
  endfunction

  function automatic logic is_done(input logic [TKN_W-1:0] tkn);
    return tkn[CTRL_BIT] && (tkn[CTRL_BIT-1:0] == DONE_PAYLOAD);
  endfunction

  function automatic logic is_stop(input logic [TKN_W-1:0] tkn);
    return tkn[CTRL_BIT] && (tkn[CTRL_BIT-1:0] <= {8'h00, STOP_MAX});
  endfunction

endpackage

// File: rtl/val_drop_stream_if.sv
// Ready/valid token channel; master drives data/valid, slave drives ready.
interface val_drop_stream_if
  import sam_tkn_pkg::*;
#(
  parameter int W = TKN_W
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/val_drop_stream_fifo.sv
// Small ready/valid register FIFO; head is always a registered entry, never a bypass.
module reg_fifo_2 #(
  parameter int DEPTH = 2,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = en & pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = en & push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/val_drop_stream.sv
// Removes zero-valued data tokens from a value/token stream; control tokens pass in order.
module val_drop_stream
  import sam_tkn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 tile_en,
  input  logic                 drop_zero,
  val_drop_stream_if.slave     up,
  val_drop_stream_if.master    dn,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int TW = DATA_WIDTH + 1;

  vds_state_t state;
  vds_state_t state_nxt;
  logic       fifo_full;
  logic       fifo_empty;
  logic       out_valid;
  logic       in_ready;
  logic       fire;
  logic       accept;
  logic       drop;
  logic       push;
  logic       cnt_clr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    out_valid = rst_n & tile_en & ~fifo_empty;
    fire      = out_valid & dn.ready & clk_en;
    in_ready  = rst_n & tile_en & (state == STREAM) & (~fifo_full | fire);
    accept    = up.valid & in_ready & clk_en;
    drop      = accept & drop_zero & ~is_ctrl(up.data) & (up.data[DATA_WIDTH-1:0] == '0);
    push      = accept & ~drop;
  end

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;

  reg_fifo_2 #(.DEPTH(FIFO_DEPTH), .W(TW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (clk_en),
    .push      (push),
    .push_data (up.data),
    .pop       (fire),
    .head      (dn.data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The block refuses input after a done token until it has left, then idles one cycle.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      STREAM: if (push && is_done(up.data)) state_nxt = DRAIN;
      DRAIN: begin
        if (clk_en && tile_en && fifo_empty) begin
          state_nxt = STREAM;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= STREAM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       drop_count <= '0;
    else if (cnt_clr) drop_count <= '0;
    else if (drop)    drop_count <= sat_inc(drop_count);
  end

endmodule

// File: tb/tb_val_drop_stream.sv
// Directed and randomized token streams against a queue-based model of the drop stage.
module tb_val_drop_stream;
  import sam_tkn_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [16:0] DN = 17'h10100;
  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] S2 = 17'h10002;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        tile_en;
  logic        drop_zero;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  val_drop_stream_if up_if ();
  val_drop_stream_if dn_if ();

  val_drop_stream #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .tile_en    (tile_en),
    .drop_zero  (drop_zero),
    .up         (up_if),
    .dn         (dn_if),
    .drop_count (drop_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: tokens held inside the block, drain flag, drop counter.
  logic [16:0] mq[$];
  bit          m_drain = 1'b0;
  int unsigned m_cnt   = 0;
  bit          chk_on  = 1'b0;
  int          ncyc    = 0;
  logic [16:0] mdl_log[$];
  logic [16:0] dut_log[$];
  logic [16:0] exp_lit[$];
  logic [16:0] src_q[$];
  int          cnt_at_done   = -1;
  int          done_fire_cyc = -1;
  int          acc9_cyc      = -1;

  int rdy_mode = 0;
  int ce_mode  = 0;
  bit te_rand  = 1'b0;
  bit dz_rand  = 1'b0;
  int cyc_i    = 0;

  always @(negedge clk) begin
    bit ev, ef, er, acc;
    logic [16:0] tok;
    ncyc++;
    if (chk_on) begin
      ev = rst_n && tile_en && (mq.size() > 0);
      ef = ev && dn_if.ready && clk_en;
      er = rst_n && tile_en && !m_drain && ((mq.size() < DEPTH) || ef);
      check("out_valid", {31'd0, dn_if.valid}, {31'd0, ev});
      check("in_ready", {31'd0, up_if.ready}, {31'd0, er});
      check("drop_count", {16'd0, drop_count}, m_cnt);
      if (ev) check("out_data", {15'd0, dn_if.data}, {15'd0, mq[0]});
      if (dn_if.valid === 1'b1 && dn_if.ready && clk_en) dut_log.push_back(dn_if.data);
      if (!rst_n) begin
        mq.delete();
        m_drain = 1'b0;
        m_cnt   = 0;
      end else if (clk_en) begin
        acc = up_if.valid && er;
        if (m_drain && mq.size() == 0 && tile_en) begin
          m_drain = 1'b0;
          m_cnt   = 0;
        end
        if (ef) begin
          tok = mq.pop_front();
          mdl_log.push_back(tok);
          if (tok == DN) begin
            cnt_at_done   = int'(m_cnt);
            done_fire_cyc = ncyc;
          end
        end
        if (acc) begin
          if (up_if.data == 17'd9) acc9_cyc = ncyc;
          if (drop_zero && !up_if.data[16] && up_if.data[15:0] == 16'd0) begin
            if (m_cnt < 32'hFFFF) m_cnt++;
          end else begin
            mq.push_back(up_if.data);
            if (up_if.data == DN) m_drain = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    bit acc;
    up_if.valid = (src_q.size() > 0);
    up_if.data  = (src_q.size() > 0) ? src_q[0] : 17'($urandom);
    case (rdy_mode)
      0:       dn_if.ready = 1'b1;
      1:       dn_if.ready = 1'($urandom_range(0, 1));
      2:       dn_if.ready = (cyc_i % 3 == 0);
      default: dn_if.ready = 1'b0;
    endcase
    case (ce_mode)
      1:       clk_en = ($urandom_range(0, 5) != 0);
      2:       clk_en = !(cyc_i >= 3 && cyc_i <= 5);
      default: clk_en = 1'b1;
    endcase
    tile_en = te_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    if (dz_rand) drop_zero = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc = up_if.valid && up_if.ready && clk_en && tile_en;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    cyc_i++;
  endtask

  task automatic run(input int budget);
    cyc_i = 0;
    while ((src_q.size() > 0 || mq.size() > 0 || m_drain) && cyc_i < budget) step();
    check("run_done", {31'd0, cyc_i < budget}, 32'd1);
    up_if.valid = 1'b0;
    clk_en      = 1'b1;
    tile_en     = 1'b1;
    src_q.delete();
  endtask

  task automatic clr_logs();
    mdl_log.delete();
    dut_log.delete();
    cnt_at_done   = -1;
    done_fire_cyc = -1;
    acc9_cyc      = -1;
  endtask

  task automatic cmp_logs(input string name);
    check({name, "_len_model"}, mdl_log.size(), exp_lit.size());
    check({name, "_len_dut"}, dut_log.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size(); i++) begin
      if (i < mdl_log.size()) check({name, "_model_tok"}, {15'd0, mdl_log[i]}, {15'd0, exp_lit[i]});
      if (i < dut_log.size()) check({name, "_dut_tok"}, {15'd0, dut_log[i]}, {15'd0, exp_lit[i]});
    end
  endtask

  function automatic logic [16:0] rand_tok();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3)      return 17'd0;
    else if (r <= 6) return {1'b0, 16'($urandom)};
    else if (r <= 8) return {1'b1, 8'h00, 8'($urandom)};
    else             return {1'b1, 16'h8000 | 16'($urandom_range(0, 255))};
  endfunction

  initial begin
    rst_n       = 1'b0;
    clk_en      = 1'b1;
    tile_en     = 1'b1;
    drop_zero   = 1'b1;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, dn_if.valid}, 32'd0);
    check("rst_count", {16'd0, drop_count}, 32'd0);
    check("rst_ready", {31'd0, up_if.ready}, 32'd1);
    @(posedge clk);
    #1;

    // T1: zeros dropped, counter cleared after the tile
    drop_zero = 1'b1;
    clr_logs();
    src_q = '{17'd5, 17'd0, 17'd7, S0, 17'd0, S1, DN};
    run(200);
    exp_lit = '{17'd5, 17'd7, S0, S1, DN};
    cmp_logs("t1");
    check("t1_cnt_at_done", cnt_at_done, 32'd2);
    check("t1_cnt_after", {16'd0, drop_count}, 32'd0);

    // T2: pass-through
    drop_zero = 1'b0;
    clr_logs();
    src_q = '{17'd5, 17'd0, 17'd7, S0, 17'd0, S1, DN};
    run(200);
    exp_lit = '{17'd5, 17'd0, 17'd7, S0, 17'd0, S1, DN};
    cmp_logs("t2");
    check("t2_cnt_at_done", cnt_at_done, 32'd0);

    // T3: downstream ready pattern 1,0,0
    drop_zero = 1'b1;
    rdy_mode  = 2;
    clr_logs();
    src_q = '{17'd3, 17'd4, 17'd5, 17'd6, S0};
    run(200);
    rdy_mode = 0;
    exp_lit = '{17'd3, 17'd4, 17'd5, 17'd6, S0};
    cmp_logs("t3");

    // T4: token after done waits for drain plus one idle cycle
    clr_logs();
    src_q = '{17'd1, 17'd2, DN, 17'd9, S0};
    run(200);
    exp_lit = '{17'd1, 17'd2, DN, 17'd9, S0};
    cmp_logs("t4");
    check("t4_gap", acc9_cyc - done_fire_cyc, 32'd2);

    // T5: reset with two tokens buffered
    rdy_mode = 3;
    clr_logs();
    src_q = '{17'd1, 17'd0, 17'd2, 17'd3};
    repeat (6) step();
    check("t5_model_depth", mq.size(), 32'd2);
    check("t5_pre_valid", {31'd0, dn_if.valid}, 32'd1);
    check("t5_pre_cnt", {16'd0, drop_count}, 32'd1);
    rst_n = 1'b0;
    src_q.delete();
    step();
    rst_n = 1'b1;
    check("t5_valid", {31'd0, dn_if.valid}, 32'd0);
    check("t5_cnt", {16'd0, drop_count}, 32'd0);
    rdy_mode = 0;
    clr_logs();
    src_q = '{17'd8, 17'd0, S2, DN};
    run(200);
    exp_lit = '{17'd8, S2, DN};
    cmp_logs("t5");

    // T6: clock enable low for three cycles mid-stream
    ce_mode = 2;
    clr_logs();
    src_q = '{17'd5, 17'd0, 17'd7, S0, DN};
    run(200);
    ce_mode = 0;
    exp_lit = '{17'd5, 17'd7, S0, DN};
    cmp_logs("t6");

    // Randomized tiles with backpressure, enable gaps and changing drop_zero
    dz_rand  = 1'b1;
    rdy_mode = 1;
    ce_mode  = 1;
    te_rand  = 1'b1;
    repeat (4) begin
      clr_logs();
      for (int i = 0; i < 40; i++) src_q.push_back(rand_tok());
      src_q.push_back(DN);
      run(3000);
      check("rand_log_len", dut_log.size(), mdl_log.size());
    end
    dz_rand  = 1'b0;
    rdy_mode = 0;
    ce_mode  = 0;
    te_rand  = 1'b0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
